// File: rtl/fc_loader_pkg.sv
// Shared types and sizing helpers for the fully-connected activation loader.
package fc_loader_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_t;

    localparam int FRAME_CNT_W = 16;

    // Index width for an IN-entry frame; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_act_loader_if.sv
// Activation stream handshake from the previous layer into the loader.
interface fc_act_loader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/fc_loader_ctrl.sv
// FILL/HOLD control: beat index, frame-length checking, frame counter and
// the write strobe for the activation array.
module fc_loader_ctrl
    import fc_loader_pkg::*;
#(
    parameter int IN    = 128,
    parameter int IDX_W = idx_w(IN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic                   x_valid,
    input  logic                   x_ready,
    output logic                   len_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   wr_en,
    output logic [IDX_W-1:0]       wr_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);

    loader_state_t          state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   len_err_q, len_err_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Ready is forced low while reset is held so nothing upstream sees a
    // handshake before the loader is running.
    assign s_ready   = rst_n && (state_q == FILL);
    assign x_valid   = (state_q == HOLD);
    assign len_err   = len_err_q;
    assign frame_cnt = frame_cnt_q;
    assign wr_idx    = idx_q;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;

        case (state_q)
            FILL: begin
                if (s_valid) begin
                    wr_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d   = HOLD;
                        idx_d     = '0;
                        len_err_d = !s_last;
                    end else if (s_last) begin
                        // Short frame: restart at slot 0, old contents stay.
                        idx_d     = '0;
                        len_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (x_ready) begin
                    state_d     = FILL;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            len_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_err_q   <= len_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/fc_act_loader.sv
// Serial-to-parallel activation loader: assembles IN activations into the
// parallel x[] input of a fully-connected layer and holds them until released.
module fc_act_loader
    import fc_loader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fc_act_loader_if.slave         s_if,
    output logic [WIDTH-1:0]       x [0:IN-1],
    output logic                   x_valid,
    input  logic                   x_ready,
    output logic                   len_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int IDX_W = idx_w(IN);

    logic             s_ready;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] x_q [0:IN-1];

    fc_loader_ctrl #(
        .IN    (IN),
        .IDX_W (IDX_W)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_if.s_valid),
        .s_last    (s_if.s_last),
        .s_ready   (s_ready),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .len_err   (len_err),
        .frame_cnt (frame_cnt),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx)
    );

    assign s_if.s_ready = s_ready;

    // NOTE: the activation array is reset because the layer consumes x
    // combinationally and must see defined zeros out of reset; plain
    // storage memories would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN; i++) begin
                x_q[i] <= '0;
            end
        end else if (wr_en) begin
            x_q[wr_idx] <= s_if.s_data;
        end
    end

    assign x = x_q;

endmodule

// File: tb/tb_fc_act_loader.sv
// Directed self-checking bench for fc_act_loader (WIDTH=8, IN=128).
module tb_fc_act_loader;

    localparam int WIDTH = 8;
    localparam int IN    = 128;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] x [0:IN-1];
    logic             x_valid;
    logic             x_ready;
    logic             len_err;
    logic [15:0]      frame_cnt;

    fc_act_loader_if #(.WIDTH(WIDTH)) s_if ();

    fc_act_loader #(
        .WIDTH (WIDTH),
        .IN    (IN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_if      (s_if),
        .x         (x),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .len_err   (len_err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_x [0:IN-1];
    int m_idx;
    int le_seen, xv_seen, sr_low_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_x(input string tag);
        int bad = 0;
        for (int i = 0; i < IN; i++) begin
            if (x[i] !== exp_x[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Streams n accepted beats (data = base + beat number, s_last on beat
    // last_idx), with idle_pct percent of cycles idle. Returns at the first
    // falling edge after the final accepting edge.
    task automatic stream(input int n, input int last_idx, input int idle_pct,
                          input logic [WIDTH-1:0] base);
        int acc = 0;
        int cyc = 0;
        le_seen     = 0;
        xv_seen     = 0;
        sr_low_seen = 0;
        while (acc < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (len_err)   le_seen++;
            if (x_valid)   xv_seen++;
            if (!s_if.s_ready) sr_low_seen++;
            s_if.s_valid = ($urandom_range(99) >= idle_pct);
            s_if.s_data  = WIDTH'(base + acc);
            s_if.s_last  = (acc == last_idx);
            if (s_if.s_valid && s_if.s_ready) begin
                exp_x[m_idx] = s_if.s_data;
                if (m_idx == IN - 1 || s_if.s_last) m_idx = 0;
                else                                m_idx++;
                acc++;
            end
        end
        if (cyc >= 2000) check("stream_timeout", acc, n);
        @(negedge clk);
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    initial begin
        int bp_bad;
        rst_n        = 1'b0;
        x_ready      = 1'b1;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        s_if.s_data  = '0;
        m_idx        = 0;
        for (int i = 0; i < IN; i++) exp_x[i] = '0;

        // Reset state
        #12;
        check("rst_s_ready", s_if.s_ready, 0);
        check("rst_x_valid", x_valid, 0);
        check("rst_len_err", len_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check_x("rst_x");
        @(negedge clk);
        rst_n = 1'b1;

        // Full frame back-to-back, consumer always ready
        stream(IN, IN - 1, 0, 8'h00);
        check("ff_sr_low_during", sr_low_seen, 0);
        check("ff_xv_during", xv_seen, 0);
        check("ff_le_during", le_seen, 0);
        check("ff_x_valid", x_valid, 1);
        check("ff_s_ready", s_if.s_ready, 0);
        check("ff_len_err", len_err, 0);
        check_x("ff_x");
        @(negedge clk);
        check("ff_x_valid_drop", x_valid, 0);
        check("ff_s_ready_back", s_if.s_ready, 1);
        check("ff_frame_cnt", frame_cnt, 1);

        // Backpressure: frame held for 50 cycles while upstream pushes 0xFF
        x_ready = 1'b0;
        stream(IN, IN - 1, 0, 8'h80);
        check("bp_x_valid", x_valid, 1);
        bp_bad = 0;
        for (int c = 0; c < 50; c++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = 8'hFF;
            @(negedge clk);
            if (s_if.s_ready !== 1'b0 || x_valid !== 1'b1) bp_bad++;
        end
        check("bp_hold_cycles", bp_bad, 0);
        check_x("bp_x_frozen");
        check("bp_frame_cnt_held", frame_cnt, 1);
        s_if.s_valid = 1'b0;
        x_ready      = 1'b1;
        @(negedge clk);
        check("bp_release_x_valid", x_valid, 0);
        check("bp_frame_cnt", frame_cnt, 2);

        // Random 30% idle gaps
        stream(IN, IN - 1, 30, 8'h40);
        check("gap_xv_early", xv_seen, 0);
        check("gap_le_during", le_seen, 0);
        check("gap_x_valid", x_valid, 1);
        check_x("gap_x");
        @(negedge clk);
        check("gap_frame_cnt", frame_cnt, 3);

        // Early s_last on index 9
        stream(10, 9, 0, 8'hA0);
        check("early_len_err", len_err, 1);
        check("early_x_valid", x_valid, 0);
        check("early_s_ready", s_if.s_ready, 1);
        @(negedge clk);
        check("early_len_err_pulse", len_err, 0);
        stream(IN, IN - 1, 0, 8'h10);
        check("early_next_xv_during", xv_seen, 0);
        check("early_next_x_valid", x_valid, 1);
        check("early_next_len_err", len_err, 0);
        check_x("early_next_x");
        @(negedge clk);
        check("early_frame_cnt", frame_cnt, 4);

        // Missing s_last on the final beat
        stream(IN, -1, 0, 8'h33);
        check("miss_le_during", le_seen, 0);
        check("miss_x_valid", x_valid, 1);
        check("miss_len_err", len_err, 1);
        check_x("miss_x");
        @(negedge clk);
        check("miss_len_err_pulse", len_err, 0);
        check("miss_frame_cnt", frame_cnt, 5);

        // Reset after 60 beats of a frame
        stream(60, -1, 0, 8'h55);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < IN; i++) exp_x[i] = '0;
        m_idx = 0;
        check("mrst_s_ready", s_if.s_ready, 0);
        check("mrst_x_valid", x_valid, 0);
        check("mrst_len_err", len_err, 0);
        check("mrst_frame_cnt", frame_cnt, 0);
        check_x("mrst_x");
        @(negedge clk);
        rst_n = 1'b1;
        stream(IN, IN - 1, 0, 8'hC0);
        check("mrst_next_xv_during", xv_seen, 0);
        check("mrst_next_x_valid", x_valid, 1);
        check_x("mrst_next_x");
        @(negedge clk);
        check("mrst_frame_cnt_after", frame_cnt, 1);

        // Frame counter wrap from 65535
        force dut.u_ctrl.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.u_ctrl.frame_cnt_q;
        @(negedge clk);
        check("wrap_preload", frame_cnt, 16'hFFFF);
        stream(IN, IN - 1, 0, 8'h07);
        check("wrap_x_valid", x_valid, 1);
        @(negedge clk);
        check("wrap_frame_cnt", frame_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
